// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU definitions (datapath width, multiplier FSM states)
package alu_pkg;
    localparam int ALU_WIDTH   = 64;
    localparam int MUL_STATE_W = 2;
    typedef enum logic [MUL_STATE_W-1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_FIX  = 2'd2
    } mul_state_t;
endpackage

// File: rtl/multiplier_seq.sv
// multiplier_seq: iterative radix-2 shift-add multiplier, signed or unsigned, 2*WIDTH-bit product
// Ports: clk, rst (sync, active-high); start/is_signed/a/b sampled in IDLE;
//        busy high during RUN and FIX; done pulses in FIX with prod_hi/prod_lo valid from then on.
module multiplier_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    mul_state_t         state, state_nx;
    logic [WIDTH-1:0]   mag_a, abs_a, abs_b;
    logic [2*WIDTH-1:0] acc, acc_nx, prod;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      cnt;
    logic               neg, last;

    // Magnitudes of the operands; the most-negative value maps to 2^(WIDTH-1), still representable unsigned.
    assign abs_a = (is_signed & a[WIDTH-1]) ? -a : a;
    assign abs_b = (is_signed & b[WIDTH-1]) ? -b : b;

    always_comb begin
        // Carry of the partial-sum add is kept and shifts into the top bit of the accumulator.
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
        acc_nx   = {sum, acc[WIDTH-1:1]};
        last     = cnt == CW'(WIDTH - 1);
        state_nx = state;
        case (state)
            MUL_IDLE: state_nx = start ? MUL_RUN : MUL_IDLE;
            MUL_RUN:  state_nx = last ? MUL_FIX : MUL_RUN;
            MUL_FIX:  state_nx = MUL_IDLE;
            default:  state_nx = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
            acc   <= '0;
            cnt   <= '0;
            mag_a <= '0;
            neg   <= 1'b0;
            prod  <= '0;
        end else begin
            state <= state_nx;
            if (state == MUL_IDLE && start) begin
                mag_a <= abs_a;
                neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                acc   <= {{WIDTH{1'b0}}, abs_b};
                cnt   <= '0;
            end else if (state == MUL_RUN) begin
                acc <= acc_nx;
                cnt <= cnt + 1'b1;
                // Sign fixup is folded into the final iteration so the product is already registered during FIX.
                if (last)
                    prod <= neg ? -acc_nx : acc_nx;
            end
        end
    end

    assign busy    = state != MUL_IDLE;
    assign done    = state == MUL_FIX;
    assign prod_hi = prod[2*WIDTH-1:WIDTH];
    assign prod_lo = prod[WIDTH-1:0];
endmodule
